button_reader: RTL and testbench

- Input-side counterpart to the board's LED output path.
- Samples WIDTH asynchronous push-button/switch pins on the MachXO2 board and synchronises each one into the OSCH clock domain.
- Debounces each channel independently, then publishes a clean level plus single-cycle press, release and long-hold event pulses.
- Application logic (LED patterns, mode selects) consumes these events instead of raw pins.

---
 rtl/button_debounce.sv | 85 ++++++++
 rtl/button_reader.sv | 34 +++
 tb/tb_button_reader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/button_debounce.sv
// One button channel: pin synchroniser, debounce filter and the event pulses
// (pressed / released / held) derived from the clean level.
module button_debounce #(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1330000,
  parameter int HOLD_CYCLES     = 133000000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic state,
  output logic pressed,
  output logic released,
  output logic held
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic              IDLE_PIN  = ACTIVE_LOW;

  logic              sync_p0, sync_p1, sync_p2;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              accept;

  // p0/p1 form the metastability synchroniser; p2 holds the level normalised
  // to 1 = pressed, so the filter never sees a raw pin.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= IDLE_PIN;
      sync_p1 <= IDLE_PIN;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= button;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1 ^ IDLE_PIN;
    end
  end

  assign accept = (sync_p2 != state) && (db_cnt == DB_LAST);

  // Debounce stage: any return to the accepted level restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= 1'b0;
      db_cnt   <= '0;
      pressed  <= 1'b0;
      released <= 1'b0;
    end else begin
      pressed  <= accept && sync_p2;
      released <= accept && !sync_p2;
      if (sync_p2 == state) begin
        db_cnt <= '0;
      end else if (accept) begin
        state  <= sync_p2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Hold stage: the press edge loads 1 so the first pressed cycle counts;
  // saturation keeps held to a single pulse per press.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt <= '0;
      held     <= 1'b0;
    end else begin
      held <= state && (hold_cnt == HOLD_FIRE);
      if (accept && sync_p2) begin
        hold_cnt <= HOLD_W'(1);
      end else if (!state) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_reader.sv
// Board button front end: WIDTH independent debounced channels publishing a
// clean level plus one-cycle press, release and long-hold pulses.
module button_reader #(
  parameter int WIDTH           = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1330000,
  parameter int HOLD_CYCLES     = 133000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] buttons,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] released,
  output logic [WIDTH-1:0] held
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    button_debounce #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .button   (buttons[i]),
      .state    (state[i]),
      .pressed  (pressed[i]),
      .released (released[i]),
      .held     (held[i])
    );
  end

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: an active-low and an active-high build run side by
// side against an event-level model, plus hand-computed timing checks.
module tb_button_reader;

  localparam int W    = 2;
  localparam int DB   = 4;
  localparam int HC   = 10;
  localparam int MAXC = 4096;

  logic clock = 1'b0;
  logic reset;
  logic [W-1:0] btn_al, btn_ah;
  logic [W-1:0] st_al, pr_al, rl_al, hd_al;
  logic [W-1:0] st_ah, pr_ah, rl_ah, hd_ah;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  button_reader #(.WIDTH(W), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC)) dut_al (
    .clock(clock), .reset(reset), .buttons(btn_al),
    .state(st_al), .pressed(pr_al), .released(rl_al), .held(hd_al));

  button_reader #(.WIDTH(W), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC)) dut_ah (
    .clock(clock), .reset(reset), .buttons(btn_ah),
    .state(st_ah), .pressed(pr_ah), .released(rl_ah), .held(hd_ah));

  // ---------------- behavioural model ----------------
  bit           rst_hist [MAXC];
  logic [W-1:0] pin_hist [2][MAXC];
  int           cyc = 0;
  bit           started = 1'b0;
  bit           m_st   [2][W];
  int           m_run  [2][W];
  int           m_rise [2][W];
  logic [W-1:0] m_state[2], m_pr[2], m_rl[2], m_hd[2];

  // Pressed-level the filter sees after edge k: pin from two edges earlier,
  // or released if any reset touched the three-edge front end.
  function automatic bit vis(input int inst, input int ch, input int k);
    if (k < 2) return 1'b0;
    if (rst_hist[k % MAXC] || rst_hist[(k-1) % MAXC] || rst_hist[(k-2) % MAXC]) return 1'b0;
    return pin_hist[inst][(k-2) % MAXC][ch] ^ (inst == 0);
  endfunction

  always @(posedge clock) begin
    bit vp, mp, mr, mh;
    rst_hist[cyc % MAXC]    = reset;
    pin_hist[0][cyc % MAXC] = btn_al;
    pin_hist[1][cyc % MAXC] = btn_ah;
    for (int inst = 0; inst < 2; inst++) begin
      for (int ch = 0; ch < W; ch++) begin
        vp = vis(inst, ch, cyc - 1);
        mp = 1'b0; mr = 1'b0; mh = 1'b0;
        if (reset) begin
          m_st[inst][ch]  = 1'b0;
          m_run[inst][ch] = 0;
        end else begin
          if (m_st[inst][ch] && (cyc - m_rise[inst][ch]) == HC - 1) mh = 1'b1;
          if (vp != m_st[inst][ch]) m_run[inst][ch]++;
          else m_run[inst][ch] = 0;
          if (m_run[inst][ch] == DB) begin
            m_st[inst][ch]  = !m_st[inst][ch];
            m_run[inst][ch] = 0;
            if (m_st[inst][ch]) begin
              mp = 1'b1;
              m_rise[inst][ch] = cyc;
            end else begin
              mr = 1'b1;
            end
          end
        end
        m_state[inst][ch] = m_st[inst][ch];
        m_pr[inst][ch] = mp;
        m_rl[inst][ch] = mr;
        m_hd[inst][ch] = mh;
      end
    end
    cyc++;
    started = 1'b1;
  end

  task automatic check_out(input int inst, input logic [W-1:0] s, p, r, h);
    vectors++;
    if ({s, p, r, h} !== {m_state[inst], m_pr[inst], m_rl[inst], m_hd[inst]}) begin
      miscompares++;
      $display("FAIL model_cmp inst%0d cyc%0d: got st=%b pr=%b rl=%b hd=%b, expected st=%b pr=%b rl=%b hd=%b",
               inst, cyc, s, p, r, h, m_state[inst], m_pr[inst], m_rl[inst], m_hd[inst]);
    end
  endtask

  always @(negedge clock) begin
    if (started) begin
      check_out(0, st_al, pr_al, rl_al, hd_al);
      check_out(1, st_ah, pr_ah, rl_ah, hd_ah);
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int np, nr, nh, rate;
    reset = 1'b1; btn_al = 2'b11; btn_ah = 2'b00;
    repeat (3) @(negedge clock);
    lit("rst_state", st_al, 0);
    lit("rst_pulses", pr_al | rl_al | hd_al, 0);

    // single press on channel 0, pin edge lands before edge 0
    reset = 1'b0; btn_al = 2'b10; btn_ah = 2'b01;
    repeat (6) @(posedge clock); #1;
    lit("press_early", pr_al, 2'b00);
    @(posedge clock); #1;
    lit("press_pulse", pr_al, 2'b01);
    lit("press_state", st_al, 2'b01);
    lit("ah_state", st_ah, 2'b01);
    @(posedge clock); #1;
    lit("press_pulse_end", pr_al, 2'b00);
    // long hold: held on edge 15, nine edges after state rose
    repeat (7) @(posedge clock); #1;
    lit("held_early", hd_al, 2'b00);
    @(posedge clock); #1;
    lit("held_pulse", hd_al, 2'b01);
    @(posedge clock); #1;
    lit("held_pulse_end", hd_al, 2'b00);
    repeat (14) @(negedge clock);
    btn_al = 2'b11;
    repeat (6) @(posedge clock); #1;
    lit("release_early", rl_al, 2'b00);
    @(posedge clock); #1;
    lit("release_pulse", rl_al, 2'b01);
    lit("release_state", st_al, 2'b00);

    // 3-cycle glitch on the active-high build is filtered out
    @(negedge clock); btn_ah = 2'b11;
    repeat (3) @(negedge clock); btn_ah = 2'b01;
    repeat (10) @(negedge clock);
    lit("ah_glitch_state", st_ah, 2'b01);

    // bounce for 20 cycles, then settle pressed
    for (int k = 0; k < 5; k++) begin
      btn_al[0] = 1'b0; repeat (2) @(negedge clock);
      btn_al[0] = 1'b1; repeat (2) @(negedge clock);
    end
    lit("bounce_state", st_al, 2'b00);
    btn_al[0] = 1'b0;
    repeat (6) @(posedge clock); #1;
    lit("settle_early", pr_al, 2'b00);
    @(posedge clock); #1;
    lit("settle_pulse", pr_al, 2'b01);
    @(negedge clock); btn_al = 2'b11;
    repeat (12) @(negedge clock);

    // short press: pressed and released, no held
    np = 0; nr = 0; nh = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (k == 0) btn_al[0] = 1'b0;
      if (k == 8) btn_al[0] = 1'b1;
      np += int'(pr_al[0]); nr += int'(rl_al[0]); nh += int'(hd_al[0]);
    end
    lit("short_pressed_cnt", np, 1);
    lit("short_released_cnt", nr, 1);
    lit("short_held_cnt", nh, 0);

    // simultaneous press, then reset mid-hold with buttons still down
    btn_al = 2'b00;
    repeat (7) @(posedge clock); #1;
    lit("simul_pressed", pr_al, 2'b11);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    lit("midhold_reset", {st_al, pr_al, rl_al, hd_al}, 0);
    @(negedge clock);
    @(negedge clock); reset = 1'b0;
    repeat (6) @(posedge clock); #1;
    lit("repress_early", pr_al, 2'b00);
    @(posedge clock); #1;
    lit("repress_pulse", pr_al, 2'b11);
    @(negedge clock); btn_al = 2'b11; btn_ah = 2'b00;
    repeat (12) @(negedge clock);

    // random phase with varying bounce density and rare resets
    rate = 6;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clock);
      if (k % 100 == 0) rate = int'($urandom_range(2, 25));
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, rate - 1) == 0) btn_al[b] = ~btn_al[b];
        if ($urandom_range(0, rate - 1) == 0) btn_ah[b] = ~btn_ah[b];
      end
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
